serial_rom_loader: RTL
======================

// Module: serial_rom_loader
// PURPOSE
//  Boot-time program loader for the Hack CPU. Takes a slow external serial link
//  (sclk_i/sdata_i, framed by sload_i) and drives the 16-bit shift register's
//  in_i/en_i. Reads back the assembled word after every 16 bits and writes it to
//  instruction ROM at consecutive addresses from 0. Holds the CPU in reset while loading.
// PARAMETERS
//  ADDR_W       15  ROM address width; depth = 2**ADDR_W words
//  SYNC_STAGES  2   flip-flop stages on each async input (sclk_i, sdata_i, sload_i), min 2
// PORTS
//  clk           in   1       system clock, all logic on posedge
//  resetb        in   1       synchronous, active-low reset
//  sclk_i        in   1       async serial clock from host; data sampled on its rising edge
//  sdata_i       in   1       async serial data, MSB of each word first
//  sload_i       in   1       async load frame; high = loading session active
//  shift_word_i  in   16      parallel output of the shift register
//  shift_in_o    out  1       serial bit to shift register in_i
//  shift_en_o    out  1       one-cycle shift enable to shift register en_i
//  rom_addr_o    out  ADDR_W  ROM write address
//  rom_data_o    out  16      ROM write data
//  rom_we_o      out  1       ROM write strobe, one cycle per word
//  cpu_hold_o    out  1       1 = keep CPU in reset
//  done_o        out  1       session finished (level)
//  error_o       out  1       session ended mid-word (level)
//  word_cnt_o    out  ADDR_W+1  words written this session
// BEHAVIOUR
//  - Reset: resetb low at a clk edge -> state IDLE. All outputs 0: rom_addr_o, word_cnt_o,
//    bit counter, pending flag, sync chains. Reset mid-write aborts; rom_we_o is 0 the next cycle.
//  - Inputs pass through SYNC_STAGES FFs. sclk edge = synced sclk 0->1. Host guarantees
//    sclk high and low times >= 4 clk cycles each.
//  - All outputs are registered.
//  - States:
//    - IDLE: wait for synced sload = 1.
//    - LOAD: bit capture.
//    - CAPT: latch word.
//    - WRITE: ROM strobe.
//    - DONE: session ended.
//  - IDLE -> LOAD on synced sload = 1. Clears rom_addr_o, word_cnt_o, bit_cnt, done_o, error_o.
//  - LOAD: each sclk edge (or pending flag) -> next cycle shift_en_o = 1 for exactly one cycle,
//    shift_in_o = synced sdata captured at the edge. bit_cnt increments 0..15.
//    The 16th pulse -> CAPT.
//  - CAPT (cycle after 16th pulse; shift_word_i now valid):
//    rom_data_o <= shift_word_i, rom_we_o <= 1 -> WRITE.
//    rom_we_o is therefore high exactly 2 cycles after the 16th shift_en_o pulse.
//  - WRITE (rom_we_o = 1 this cycle): next cycle rom_we_o = 0 and word_cnt_o += 1.
//    - If rom_addr_o == 2**ADDR_W-1 or synced sload = 0 -> DONE, rom_addr_o held.
//    - Else rom_addr_o += 1 and -> LOAD.
//  - An sclk edge seen in CAPT/WRITE sets pending. It is issued as a shift pulse on
//    return to LOAD, so no bit is lost. Pending is cleared on entering DONE.
//  - sload falls in LOAD:
//    - bit_cnt == 0 -> DONE, error_o = 0.
//    - bit_cnt != 0 -> DONE, error_o = 1, partial word discarded (no write).
//  - sload falls in CAPT/WRITE: the in-flight write completes, then -> DONE.
//  - DONE: done_o = 1; sclk edges ignored. synced sload 0->1 -> LOAD (new session from address 0).
//    In DONE after ROM full, sload must drop first.
//  - cpu_hold_o = 1 in LOAD/CAPT/WRITE, 0 in IDLE/DONE. shift_en_o is never 1 outside LOAD.
// TESTING
//  - Reset: hold resetb low 3 cycles with sclk toggling -> all outputs 0, no shift_en_o pulses.
//  - One word: sload=1, send 0xABCD MSB first -> 16 shift_en_o pulses with bits 1,0,1,0,1,0,1,1,
//    1,1,0,0,1,1,0,1. Shift-register model yields 0xABCD. rom_we_o=1 with addr 0, data 0xABCD,
//    2 cycles after the 16th pulse.
//  - Three words 0x0001,0x8000,0xFFFF, then sload=0 -> writes at addr 0,1,2;
//    word_cnt_o=3, done_o=1, error_o=0, cpu_hold_o=0.
//  - Abort: 5 bits, then sload=0 -> no rom_we_o, done_o=1, error_o=1.
//    Re-raise sload -> new session restarts at addr 0 with errors cleared.
//  - Full: ADDR_W=2, send 5 words -> 4 writes (addr 0..3), DONE after the 4th; 5th word ignored.
//  - Back-to-back: next word's first sclk edge lands in CAPT -> pending pulse issued in LOAD,
//    second word correct. resetb low during WRITE -> rom_we_o=0 next cycle, state IDLE.

Source files
------------

// File: rtl/serial_rom_loader.sv
// Boot loader: deserialises a slow host bit stream through the external 16-bit
// shift register and writes each assembled word to instruction ROM from address 0.
module serial_rom_loader #(
    parameter int ADDR_W      = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sclk_i,
    input  logic              sdata_i,
    input  logic              sload_i,
    input  logic [15:0]       shift_word_i,
    output logic              shift_in_o,
    output logic              shift_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [15:0]       rom_data_o,
    output logic              rom_we_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] sload_sync;
    logic                   sclk_prev;
    logic                   sload_prev;

    logic sclk_s;
    logic sdata_s;
    logic sload_s;
    logic sclk_rise;
    logic sload_rise;
    logic start_req;

    state_t     state;
    logic [3:0] bit_cnt;
    logic       last_pulse;
    logic       pending;
    logic       pending_bit;

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync[SYNC_STAGES-1];
    assign sload_s    = sload_sync[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign sload_rise = sload_s & ~sload_prev;

    // From IDLE a held-high frame starts a session; from DONE only a fresh rise does,
    // so a session that filled the ROM cannot restart until the host drops sload.
    assign start_req = (state == IDLE) ? sload_s :
                       (state == DONE) ? sload_rise : 1'b0;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            sload_sync <= '0;
            sclk_prev  <= 1'b0;
            sload_prev <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_i};
            sload_sync <= {sload_sync[SYNC_STAGES-2:0], sload_i};
            sclk_prev  <= sclk_s;
            sload_prev <= sload_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            last_pulse  <= 1'b0;
            pending     <= 1'b0;
            pending_bit <= 1'b0;
            shift_in_o  <= 1'b0;
            shift_en_o  <= 1'b0;
            rom_addr_o  <= '0;
            rom_data_o  <= 16'h0000;
            rom_we_o    <= 1'b0;
            cpu_hold_o  <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            shift_en_o <= 1'b0;
            rom_we_o   <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start_req) begin
                        state       <= LOAD;
                        rom_addr_o  <= '0;
                        word_cnt_o  <= '0;
                        bit_cnt     <= 4'd0;
                        last_pulse  <= 1'b0;
                        pending     <= 1'b0;
                        done_o      <= 1'b0;
                        error_o     <= 1'b0;
                        cpu_hold_o  <= 1'b1;
                    end
                end

                LOAD: begin
                    if (last_pulse) begin
                        // 16th pulse is on the wire now; the word is readable next cycle.
                        last_pulse <= 1'b0;
                        state      <= CAPT;
                        if (sclk_rise) begin
                            pending     <= 1'b1;
                            pending_bit <= sdata_s;
                        end
                    end else if (!sload_s) begin
                        state      <= DONE;
                        done_o     <= 1'b1;
                        cpu_hold_o <= 1'b0;
                        error_o    <= (bit_cnt != 4'd0) || pending;
                        pending    <= 1'b0;
                    end else if (pending || sclk_rise) begin
                        shift_en_o <= 1'b1;
                        bit_cnt    <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            last_pulse <= 1'b1;
                        end
                        if (pending) begin
                            shift_in_o  <= pending_bit;
                            pending     <= sclk_rise;
                            pending_bit <= sdata_s;
                        end else begin
                            shift_in_o <= sdata_s;
                        end
                    end
                end

                CAPT: begin
                    rom_data_o <= shift_word_i;
                    rom_we_o   <= 1'b1;
                    state      <= WRITE;
                    if (sclk_rise) begin
                        pending     <= 1'b1;
                        pending_bit <= sdata_s;
                    end
                end

                WRITE: begin
                    word_cnt_o <= word_cnt_o + CNT_ONE;
                    if ((rom_addr_o == ADDR_MAX) || !sload_s) begin
                        state      <= DONE;
                        done_o     <= 1'b1;
                        cpu_hold_o <= 1'b0;
                        pending    <= 1'b0;
                    end else begin
                        rom_addr_o <= rom_addr_o + ADDR_ONE;
                        state      <= LOAD;
                        if (sclk_rise) begin
                            pending     <= 1'b1;
                            pending_bit <= sdata_s;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    cpu_hold_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
